// File: rtl/wb_sel_pipe_ctrl.sv
// rtl/wb_sel_pipe_ctrl.sv - writeback-source select pipeline (EX/MEM/WB) with load-use detection
// Optional macro WB_SEL_STATS_EN adds saturating load-use and flush event counters.
module wb_sel_pipe_ctrl #(
   parameter int RD_W       = 5,
   parameter bit ILLEGAL_WE = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [6:0]      id_opcode,
   input  logic [RD_W-1:0] id_rd,
   input  logic [RD_W-1:0] id_rs1,
   input  logic [RD_W-1:0] id_rs2,
   input  logic            stall_i,
   input  logic            flush_i,
   output logic            id_accept,
   output logic            load_use_stall,
   output logic [1:0]      ex_sel,
   output logic [1:0]      mem_sel,
   output logic [1:0]      wb_sel,
   output logic            wb_we,
   output logic [RD_W-1:0] wb_rd
`ifdef WB_SEL_STATS_EN
   ,
   output logic [15:0]     cnt_load_use,
   output logic [15:0]     cnt_flush
`endif
);

   logic [1:0]      dec_sel;
   logic            dec_we;
   logic            dec_ld;

   logic            ex_valid, ex_we, ex_ld;
   logic [1:0]      ex_sel_q;
   logic [RD_W-1:0] ex_rd;
   logic            mem_valid, mem_we;
   logic [1:0]      mem_sel_q;
   logic [RD_W-1:0] mem_rd;
   logic            wb_valid, wb_we_q;
   logic [1:0]      wb_sel_q;
   logic [RD_W-1:0] wb_rd_q;

   logic            bubble;

   always_comb begin
      dec_sel = 2'b00;
      dec_we  = ILLEGAL_WE;
      dec_ld  = 1'b0;
      case (id_opcode)
         7'b0000011: begin dec_sel = 2'b00; dec_we = 1'b1; dec_ld = 1'b1; end
         7'b0110011,
         7'b0010011: begin dec_sel = 2'b00; dec_we = 1'b1; end
         7'b1101111,
         7'b1100111: begin dec_sel = 2'b01; dec_we = 1'b1; end
         7'b0010111: begin dec_sel = 2'b10; dec_we = 1'b1; end
         7'b0110111: begin dec_sel = 2'b11; dec_we = 1'b1; end
         7'b0100011,
         7'b1100011: begin dec_sel = 2'b00; dec_we = 1'b0; end
         default:    begin dec_sel = 2'b00; dec_we = ILLEGAL_WE; end
      endcase
      // x0 is hardwired; never write it regardless of opcode.
      if (id_rd == '0)
         dec_we = 1'b0;
   end

   assign load_use_stall = ex_valid & ex_ld & ex_we & id_valid &
                           ((ex_rd == id_rs1) | (ex_rd == id_rs2));
   assign bubble         = flush_i | load_use_stall;
   assign id_accept      = id_valid & ~stall_i & ~bubble;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid  <= 1'b0; ex_we  <= 1'b0; ex_ld <= 1'b0; ex_sel_q <= 2'b00; ex_rd <= '0;
         mem_valid <= 1'b0; mem_we <= 1'b0; mem_sel_q <= 2'b00; mem_rd <= '0;
         wb_valid  <= 1'b0; wb_we_q <= 1'b0; wb_sel_q <= 2'b00; wb_rd_q <= '0;
      end else if (!stall_i) begin
         mem_valid <= ex_valid;  mem_we  <= ex_we;  mem_sel_q <= ex_sel_q;  mem_rd  <= ex_rd;
         wb_valid  <= mem_valid; wb_we_q <= mem_we; wb_sel_q  <= mem_sel_q; wb_rd_q <= mem_rd;
         if (bubble) begin
            ex_valid <= 1'b0; ex_we <= 1'b0; ex_ld <= 1'b0; ex_sel_q <= 2'b00; ex_rd <= '0;
         end else begin
            ex_valid <= id_valid;
            ex_we    <= dec_we;
            ex_ld    <= dec_ld;
            ex_sel_q <= dec_sel;
            ex_rd    <= id_rd;
         end
      end
   end

   assign ex_sel  = ex_valid  ? ex_sel_q  : 2'b00;
   assign mem_sel = mem_valid ? mem_sel_q : 2'b00;
   assign wb_sel  = wb_valid  ? wb_sel_q  : 2'b00;
   assign wb_we   = wb_valid & wb_we_q;
   assign wb_rd   = wb_valid ? wb_rd_q : '0;

`ifdef WB_SEL_STATS_EN
   // Count only events that actually change state, i.e. not while frozen.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_load_use <= 16'h0000;
         cnt_flush    <= 16'h0000;
      end else if (!stall_i) begin
         if (flush_i && cnt_flush != 16'hFFFF)
            cnt_flush <= cnt_flush + 16'h0001;
         if (!flush_i && load_use_stall && cnt_load_use != 16'hFFFF)
            cnt_load_use <= cnt_load_use + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_wb_sel_pipe_ctrl.sv
// tb/tb_wb_sel_pipe_ctrl.sv - directed self-checking bench for wb_sel_pipe_ctrl
module tb_wb_sel_pipe_ctrl;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_OP    = 7'b0110011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid;
   logic [6:0] id_opcode;
   logic [4:0] id_rd, id_rs1, id_rs2;
   logic       stall_i, flush_i;
   logic       id_accept, load_use_stall;
   logic [1:0] ex_sel, mem_sel, wb_sel;
   logic       wb_we;
   logic [4:0] wb_rd;
`ifdef WB_SEL_STATS_EN
   logic [15:0] cnt_load_use, cnt_flush;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   wb_sel_pipe_ctrl dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .stall_i(stall_i), .flush_i(flush_i),
      .id_accept(id_accept), .load_use_stall(load_use_stall),
      .ex_sel(ex_sel), .mem_sel(mem_sel), .wb_sel(wb_sel),
      .wb_we(wb_we), .wb_rd(wb_rd)
`ifdef WB_SEL_STATS_EN
      , .cnt_load_use(cnt_load_use), .cnt_flush(cnt_flush)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
      id_valid  = v;
      id_opcode = op;
      id_rd     = rd;
      id_rs1    = rs1;
      id_rs2    = rs2;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
      set_id(1'b0, 7'b0, 5'd0, 5'd0, 5'd0);
      tick(); tick();
      rst_n = 1'b1;
      #1;
      n_checks++;
      if ({ex_sel, mem_sel, wb_sel, wb_we, wb_rd} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected 000", {ex_sel, mem_sel, wb_sel, wb_we, wb_rd});
      end
      n_checks++;
      if ({id_accept, load_use_stall} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_handshake: got %b expected 00", {id_accept, load_use_stall});
      end
   endtask

   task automatic test_single_lui();
      set_id(1'b1, OP_LUI, 5'd5, 5'd0, 5'd0);
      n_checks++;
      if (id_accept !== 1'b1) begin n_fail++; $display("FAIL lui_accept: got %b expected 1", id_accept); end
      tick();
      set_id(1'b0, 7'b0, 5'd0, 5'd0, 5'd0);
      n_checks++;
      if ({ex_sel, wb_we} !== 3'b110) begin n_fail++; $display("FAIL lui_ex: got %b expected 110", {ex_sel, wb_we}); end
      tick();
      n_checks++;
      if ({mem_sel, wb_we} !== 3'b110) begin n_fail++; $display("FAIL lui_mem: got %b expected 110", {mem_sel, wb_we}); end
      tick();
      n_checks++;
      if ({wb_sel, wb_we, wb_rd} !== {2'b11, 1'b1, 5'd5}) begin
         n_fail++; $display("FAIL lui_wb: got %b expected %b", {wb_sel, wb_we, wb_rd}, {2'b11, 1'b1, 5'd5});
      end
      tick();
      n_checks++;
      if ({wb_sel, wb_we, wb_rd} !== 8'h00) begin
         n_fail++; $display("FAIL lui_wb_once: got %b expected 00000000", {wb_sel, wb_we, wb_rd});
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_wb [4];
      exp_wb[0] = {2'b10, 1'b1, 5'd1};
      exp_wb[1] = {2'b01, 1'b1, 5'd2};
      exp_wb[2] = {2'b00, 1'b1, 5'd3};
      exp_wb[3] = {2'b00, 1'b0, 5'd0};
      set_id(1'b1, OP_AUIPC, 5'd1, 5'd0, 5'd0);  tick();
      set_id(1'b1, OP_JALR,  5'd2, 5'd1, 5'd0);  tick();
      set_id(1'b1, OP_LOAD,  5'd3, 5'd2, 5'd0);
      n_checks++;
      if (id_accept !== 1'b1) begin n_fail++; $display("FAIL b2b_load_accept: got %b expected 1", id_accept); end
      tick();
      set_id(1'b1, OP_STORE, 5'd0, 5'd10, 5'd11);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if ({wb_sel, wb_we, wb_rd} !== exp_wb[i]) begin
            n_fail++; $display("FAIL b2b_wb[%0d]: got %b expected %b", i, {wb_sel, wb_we, wb_rd}, exp_wb[i]);
         end
         tick();
         set_id(1'b0, 7'b0, 5'd0, 5'd0, 5'd0);
      end
   endtask

   task automatic test_load_use();
      set_id(1'b1, OP_LOAD, 5'd7, 5'd1, 5'd2);  tick();
      set_id(1'b1, OP_OP,   5'd8, 5'd7, 5'd0);
      n_checks++;
      if ({load_use_stall, id_accept} !== 2'b10) begin
         n_fail++; $display("FAIL lu_stall: got %b expected 10", {load_use_stall, id_accept});
      end
      tick();
      n_checks++;
      if ({load_use_stall, id_accept, ex_sel, mem_sel} !== 6'b010000) begin
         n_fail++; $display("FAIL lu_release: got %b expected 010000", {load_use_stall, id_accept, ex_sel, mem_sel});
      end
      tick();
      set_id(1'b0, 7'b0, 5'd0, 5'd0, 5'd0);
      n_checks++;
      if ({wb_sel, wb_we, wb_rd} !== {2'b00, 1'b1, 5'd7}) begin
         n_fail++; $display("FAIL lu_load_wb: got %b expected %b", {wb_sel, wb_we, wb_rd}, {2'b00, 1'b1, 5'd7});
      end
      tick();
      n_checks++;
      if (wb_we !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_wb: got %b expected 0", wb_we); end
      tick();
      n_checks++;
      if ({wb_sel, wb_we, wb_rd} !== {2'b00, 1'b1, 5'd8}) begin
         n_fail++; $display("FAIL lu_add_wb: got %b expected %b", {wb_sel, wb_we, wb_rd}, {2'b00, 1'b1, 5'd8});
      end
      tick();
   endtask

   task automatic test_flush();
      set_id(1'b1, OP_AUIPC, 5'd6, 5'd0, 5'd0);  tick();
      set_id(1'b1, OP_LUI,   5'd9, 5'd0, 5'd0);
      flush_i = 1'b1;
      #1;
      n_checks++;
      if (id_accept !== 1'b0) begin n_fail++; $display("FAIL flush_accept: got %b expected 0", id_accept); end
      tick();
      flush_i = 1'b0;
      set_id(1'b0, 7'b0, 5'd0, 5'd0, 5'd0);
      n_checks++;
      if ({ex_sel, mem_sel} !== 4'b0010) begin
         n_fail++; $display("FAIL flush_ex_bubble: got %b expected 0010", {ex_sel, mem_sel});
      end
      tick();
      n_checks++;
      if ({wb_sel, wb_we, wb_rd} !== {2'b10, 1'b1, 5'd6}) begin
         n_fail++; $display("FAIL flush_older_retires: got %b expected %b", {wb_sel, wb_we, wb_rd}, {2'b10, 1'b1, 5'd6});
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if (wb_we !== 1'b0) begin n_fail++; $display("FAIL flush_killed[%0d]: got wb_we %b expected 0", i, wb_we); end
      end
   endtask

   task automatic test_stall();
      set_id(1'b1, OP_LUI, 5'd4, 5'd0, 5'd0);  tick();
      set_id(1'b1, OP_JAL, 5'd2, 5'd0, 5'd0);  tick();
      set_id(1'b0, 7'b0,   5'd0, 5'd0, 5'd0);  tick();
      stall_i = 1'b1;
      set_id(1'b1, OP_LUI, 5'd9, 5'd0, 5'd0);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({id_accept, ex_sel, mem_sel, wb_sel, wb_we, wb_rd} !== {1'b0, 2'b00, 2'b01, 2'b11, 1'b1, 5'd4}) begin
            n_fail++; $display("FAIL stall_hold[%0d]: got %b expected %b", i,
                               {id_accept, ex_sel, mem_sel, wb_sel, wb_we, wb_rd},
                               {1'b0, 2'b00, 2'b01, 2'b11, 1'b1, 5'd4});
         end
         tick();
      end
      stall_i = 1'b0;
      set_id(1'b0, 7'b0, 5'd0, 5'd0, 5'd0);
      tick();
      n_checks++;
      if ({wb_sel, wb_we, wb_rd} !== {2'b01, 1'b1, 5'd2}) begin
         n_fail++; $display("FAIL stall_resume: got %b expected %b", {wb_sel, wb_we, wb_rd}, {2'b01, 1'b1, 5'd2});
      end
      tick(); tick();
   endtask

   task automatic test_x0_and_reset();
      set_id(1'b1, OP_LUI, 5'd0, 5'd0, 5'd0);  tick();
      set_id(1'b0, 7'b0,   5'd0, 5'd0, 5'd0);  tick(); tick();
      n_checks++;
      if ({wb_sel, wb_we, wb_rd} !== {2'b11, 1'b0, 5'd0}) begin
         n_fail++; $display("FAIL x0_no_write: got %b expected %b", {wb_sel, wb_we, wb_rd}, {2'b11, 1'b0, 5'd0});
      end
      set_id(1'b1, OP_AUIPC, 5'd3, 5'd0, 5'd0);  tick();
      set_id(1'b1, OP_LUI,   5'd5, 5'd0, 5'd0);  tick();
      set_id(1'b0, 7'b0,     5'd0, 5'd0, 5'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      n_checks++;
      if ({ex_sel, mem_sel, wb_sel, wb_we, wb_rd} !== 12'h000) begin
         n_fail++; $display("FAIL midreset_outputs: got %h expected 000", {ex_sel, mem_sel, wb_sel, wb_we, wb_rd});
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (wb_we !== 1'b0) begin n_fail++; $display("FAIL midreset_retire[%0d]: got wb_we %b expected 0", i, wb_we); end
      end
   endtask

   initial begin
      test_reset();
      test_single_lui();
      test_back_to_back();
      test_load_use();
      test_flush();
      test_stall();
      test_x0_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
